// File: rtl/usb_sniffer_fifo_param.sv
// Parametrised capture FIFO for the USB sniffer.
// Push side: data_in_i/push_i with accept_o. Pop side: first-word-fall-through
// data_out_o/valid_o/pop_i. Status: level_o, almost_full_o, sticky overflow_o,
// saturating drop_count_o. flush_i synchronously empties the FIFO and clears status.
// Storage is a dual-port RAM with a registered read feeding a one-word output stage.
module usb_sniffer_fifo_param #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned ADDR_W       = 11,
   parameter int unsigned AFULL_THRESH = (1 << ADDR_W) - 16,
   parameter int unsigned DROP_W       = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic [WIDTH-1:0]  data_in_i,
   input  logic              push_i,
   output logic              accept_o,
   output logic [WIDTH-1:0]  data_out_o,
   output logic              valid_o,
   input  logic              pop_i,
   output logic [ADDR_W:0]   level_o,
   output logic              almost_full_o,
   output logic              overflow_o,
   output logic [DROP_W-1:0] drop_count_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned PTR_W = ADDR_W + 1;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [WIDTH-1:0]  ram_rdata_q;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  level_q, level_d;
   logic              rvalid_q, rvalid_d;     // RAM read register holds a word
   logic              valid_q, valid_d;       // output stage holds a word
   logic [WIDTH-1:0]  dout_q, dout_d;
   logic              accept_q, accept_d;
   logic              afull_q, afull_d;
   logic              ovf_q, ovf_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

   logic              wr_en;
   logic              rd_en;
   logic              pop_ok;
   logic              drop;
   logic              s2_load;

   // Next-state computation for pointers, pipeline stages and status
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      rvalid_d   = rvalid_q;
      valid_d    = valid_q;
      dout_d     = dout_q;
      ovf_d      = ovf_q;
      drop_cnt_d = drop_cnt_q;

      wr_en   = push_i & accept_q & ~flush_i;
      drop    = push_i & ~accept_q & ~flush_i;
      pop_ok  = pop_i & valid_q & ~flush_i;
      // RAM word moves into the output stage when that stage is free or being emptied
      s2_load = rvalid_q & (~valid_q | pop_ok) & ~flush_i;
      // A new RAM read is launched only when the read register will be free next cycle
      rd_en   = (wr_ptr_q != rd_ptr_q) & (~rvalid_q | s2_load) & ~flush_i;

      if (flush_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         rvalid_d   = 1'b0;
         valid_d    = 1'b0;
         dout_d     = '0;
         ovf_d      = 1'b0;
         drop_cnt_d = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         level_d = level_q + PTR_W'(wr_en) - PTR_W'(pop_ok);

         if (rd_en)        rvalid_d = 1'b1;
         else if (s2_load) rvalid_d = 1'b0;

         if (s2_load) begin
            valid_d = 1'b1;
            dout_d  = ram_rdata_q;
         end else if (pop_ok) begin
            valid_d = 1'b0;
         end

         if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != {DROP_W{1'b1}}) drop_cnt_d = drop_cnt_q + DROP_W'(1);
         end
      end

      accept_d = 32'(level_d) < DEPTH;
      afull_d  = 32'(level_d) >= AFULL_THRESH;
   end

   // RAM: write port plus registered read port, contents never reset
   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= data_in_i;
      if (rd_en) ram_rdata_q <= mem[rd_ptr_q[ADDR_W-1:0]];
   end

   // Control and status registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         rvalid_q   <= 1'b0;
         valid_q    <= 1'b0;
         dout_q     <= '0;
         accept_q   <= 1'b1;
         afull_q    <= 1'b0;
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         rvalid_q   <= rvalid_d;
         valid_q    <= valid_d;
         dout_q     <= dout_d;
         accept_q   <= accept_d;
         afull_q    <= afull_d;
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign accept_o      = accept_q;
   assign data_out_o    = dout_q;
   assign valid_o       = valid_q;
   assign level_o       = level_q;
   assign almost_full_o = afull_q;
   assign overflow_o    = ovf_q;
   assign drop_count_o  = drop_cnt_q;

endmodule

// File: tb/tb_usb_sniffer_fifo_param.sv
// Bench for usb_sniffer_fifo_param with ADDR_W=4 (16 words), AFULL_THRESH=12, DROP_W=4.
// Reference model: a queue of (word, push edge) pairs; the head is visible once
// two edges have passed since it was pushed.
module tb_usb_sniffer_fifo_param;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned AFULL  = 12;
   localparam int unsigned DROP_W = 4;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned DSAT   = 15;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              flush_i;
   logic [WIDTH-1:0]  data_in_i;
   logic              push_i;
   logic              accept_o;
   logic [WIDTH-1:0]  data_out_o;
   logic              valid_o;
   logic              pop_i;
   logic [ADDR_W:0]   level_o;
   logic              almost_full_o;
   logic              overflow_o;
   logic [DROP_W-1:0] drop_count_o;

   usb_sniffer_fifo_param #(
      .WIDTH(WIDTH), .ADDR_W(ADDR_W), .AFULL_THRESH(AFULL), .DROP_W(DROP_W)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .data_in_i(data_in_i), .push_i(push_i), .accept_o(accept_o),
      .data_out_o(data_out_o), .valid_o(valid_o), .pop_i(pop_i),
      .level_o(level_o), .almost_full_o(almost_full_o),
      .overflow_o(overflow_o), .drop_count_o(drop_count_o)
   );

   always #5 clk_i = ~clk_i;

   // reference model state
   logic [WIDTH-1:0] mq_d[$];
   int               mq_t[$];
   int               edge_n;
   bit               m_ovf;
   int               m_drop;

   int n_cmp;
   int n_bad;

   typedef struct {
      bit               push;
      bit               pop;
      logic [WIDTH-1:0] din;
      int               lvl;
      bit               vld;
      logic [WIDTH-1:0] dout;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_valid();
      return (mq_d.size() > 0) && (edge_n >= mq_t[0] + 2);
   endfunction

   task automatic model_reset();
      mq_d.delete();
      mq_t.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
   endtask

   task automatic check_model();
      chk("level", 32'(level_o), 32'(mq_d.size()));
      chk("accept", 32'(accept_o), 32'(mq_d.size() < DEPTH));
      chk("almost_full", 32'(almost_full_o), 32'(mq_d.size() >= AFULL));
      chk("overflow", 32'(overflow_o), 32'(m_ovf));
      chk("drop_count", 32'(drop_count_o), 32'(m_drop));
      chk("valid", 32'(valid_o), 32'(m_valid()));
      if (m_valid()) chk("data_out", data_out_o, mq_d[0]);
   endtask

   // One clock: drive inputs after a falling edge, update model at the rising edge,
   // compare at the next falling edge.
   task automatic step(input bit push, input logic [WIDTH-1:0] d, input bit pop, input bit flush);
      bit pv;
      int sz;
      push_i    = push;
      data_in_i = d;
      pop_i     = pop;
      flush_i   = flush;
      pv = m_valid();
      sz = mq_d.size();
      @(posedge clk_i);
      edge_n++;
      if (flush) begin
         model_reset();
      end else begin
         if (pop && pv) begin
            void'(mq_d.pop_front());
            void'(mq_t.pop_front());
         end
         if (push) begin
            if (sz < DEPTH) begin
               mq_d.push_back(d);
               mq_t.push_back(edge_n);
            end else begin
               m_ovf = 1'b1;
               if (m_drop < DSAT) m_drop++;
            end
         end
      end
      @(negedge clk_i);
      push_i  = 1'b0;
      pop_i   = 1'b0;
      flush_i = 1'b0;
      data_in_i = '0;
      check_model();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      edge_n = 0;
      model_reset();
      flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; data_in_i = '0;
      rst_ni = 1'b1;
      #1 rst_ni = 1'b0;
      #1;
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_accept", 32'(accept_o), 1);
      chk("rst_level", 32'(level_o), 0);
      chk("rst_drop", 32'(drop_count_o), 0);
      @(negedge clk_i);
      @(negedge clk_i);
      check_model();
      rst_ni = 1'b1;

      // idle with a stray pop
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);

      // fill to full, then overflow
      for (int i = 0; i < 16; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
      chk("full_level", 32'(level_o), 16);
      chk("full_accept", 32'(accept_o), 0);
      chk("full_afull", 32'(almost_full_o), 1);
      step(1'b1, 32'h1FF, 1'b0, 1'b0);
      chk("ovf_flag", 32'(overflow_o), 1);
      chk("ovf_drop", 32'(drop_count_o), 1);
      chk("ovf_level", 32'(level_o), 16);
      // push+pop at full: push still dropped
      step(1'b1, 32'h1EE, 1'b1, 1'b0);
      chk("pp_full_level", 32'(level_o), 15);
      chk("pp_full_drop", 32'(drop_count_o), 2);
      step(1'b1, 32'h110, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) step(1'b1, 32'hDEAD, 1'b0, 1'b0);
      chk("drop_saturate", 32'(drop_count_o), DSAT);

      // drain in order
      for (int i = 0; i < 16; i++) begin
         chk("drain_valid", 32'(valid_o), 1);
         chk("drain_data", data_out_o, 32'h101 + 32'(i));
         step(1'b0, '0, 1'b1, 1'b0);
      end
      chk("drain_empty", 32'(valid_o), 0);
      step(1'b0, '0, 1'b0, 1'b1);

      // backpressure table
      tbl[0] = '{1'b1, 1'b0, 32'hA, 1, 1'b0, 32'h0};
      tbl[1] = '{1'b1, 1'b0, 32'hB, 2, 1'b0, 32'h0};
      tbl[2] = '{1'b0, 1'b0, 32'h0, 2, 1'b1, 32'hA};
      tbl[3] = '{1'b0, 1'b0, 32'h0, 2, 1'b1, 32'hA};
      tbl[4] = '{1'b0, 1'b0, 32'h0, 2, 1'b1, 32'hA};
      tbl[5] = '{1'b0, 1'b0, 32'h0, 2, 1'b1, 32'hA};
      tbl[6] = '{1'b0, 1'b0, 32'h0, 2, 1'b1, 32'hA};
      tbl[7] = '{1'b0, 1'b1, 32'h0, 1, 1'b1, 32'hB};
      tbl[8] = '{1'b0, 1'b1, 32'h0, 0, 1'b0, 32'h0};
      tbl[9] = '{1'b0, 1'b1, 32'h0, 0, 1'b0, 32'h0};
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].push, tbl[i].din, tbl[i].pop, 1'b0);
         chk("tbl_level", 32'(level_o), 32'(tbl[i].lvl));
         chk("tbl_valid", 32'(valid_o), 32'(tbl[i].vld));
         if (tbl[i].vld) chk("tbl_data", data_out_o, tbl[i].dout);
      end

      // random stream with wrap: push-heavy then pop-heavy phases
      for (int i = 0; i < 400; i++) begin
         bit p, q;
         if ((i / 50) % 2 == 0) begin
            p = $urandom_range(0, 99) < 75;
            q = $urandom_range(0, 99) < 40;
         end else begin
            p = $urandom_range(0, 99) < 35;
            q = $urandom_range(0, 99) < 80;
         end
         step(p, $urandom, q, 1'b0);
         chk("level_bound", 32'(level_o <= 5'd16), 1);
      end
      for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);

      // flush mid-stream with 7 words held and overflow set
      for (int i = 0; i < 17; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b0);
      chk("pre_flush_level", 32'(level_o), 7);
      chk("pre_flush_ovf", 32'(overflow_o), 1);
      step(1'b1, 32'h77, 1'b1, 1'b1);
      chk("flush_level", 32'(level_o), 0);
      chk("flush_valid", 32'(valid_o), 0);
      chk("flush_ovf", 32'(overflow_o), 0);
      chk("flush_drop", 32'(drop_count_o), 0);
      chk("flush_accept", 32'(accept_o), 1);
      step(1'b1, 32'h55, 1'b0, 1'b0);
      chk("lat_n0", 32'(valid_o), 0);
      step(1'b0, '0, 1'b0, 1'b0);
      chk("lat_n1", 32'(valid_o), 0);
      step(1'b0, '0, 1'b0, 1'b0);
      chk("lat_n2_valid", 32'(valid_o), 1);
      chk("lat_n2_data", data_out_o, 32'h55);
      step(1'b0, '0, 1'b1, 1'b0);

      // asynchronous reset between edges with 5 words held
      for (int i = 0; i < 5; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
      chk("pre_rst_level", 32'(level_o), 5);
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_level", 32'(level_o), 0);
      chk("arst_valid", 32'(valid_o), 0);
      chk("arst_data", data_out_o, 0);
      chk("arst_accept", 32'(accept_o), 1);
      chk("arst_afull", 32'(almost_full_o), 0);
      chk("arst_ovf", 32'(overflow_o), 0);
      chk("arst_drop", 32'(drop_count_o), 0);
      model_reset();
      @(negedge clk_i);
      check_model();
      rst_ni = 1'b1;
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, 32'hC0DE, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      chk("post_rst_data", data_out_o, 32'hC0DE);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("post_rst_empty", 32'(valid_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/usb_sniffer_fifo_param.md
Name: usb_sniffer_fifo_param

Overview:
- Parametrised successor to the sniffer's capture FIFO: width and depth are configurable, and the full 2^ADDR_W entries are usable.
- Adds an occupancy level, an almost-full flag, synchronous flush, a sticky overflow flag and a saturating dropped-word counter.
- Sits between the USB capture/packing logic (push side) and the memory writer or bus master (pop side).
- Single clock domain, dual-port RAM storage, first-word-fall-through read side with a skid buffer.

Parameters:
- WIDTH, 32, data word width in bits.
- ADDR_W, 11, RAM address width; DEPTH = 2^ADDR_W words.
- AFULL_THRESH, 2^ADDR_W-16, level at or above which almost_full_o asserts.
- DROP_W, 16, width of the dropped-word counter.

Ports:
- clk_i  input  1  clock, all logic on the rising edge
- rst_ni  input  1  asynchronous, active-low reset
- flush_i  input  1  synchronous clear of all contents and status
- data_in_i  input  WIDTH  write data
- push_i  input  1  write request
- accept_o  output  1  FIFO can take a word this cycle
- data_out_o  output  WIDTH  head-of-queue data, valid when valid_o=1
- valid_o  output  1  data_out_o holds a word
- pop_i  input  1  consumer takes the word when valid_o=1
- level_o  output  ADDR_W+1  words pushed and not yet popped (includes words in the output stage)
- almost_full_o  output  1  level_o >= AFULL_THRESH
- overflow_o  output  1  sticky: at least one push was dropped
- drop_count_o  output  DROP_W  number of dropped pushes, saturating

Behaviour:
- Reset (rst_ni=0, async): pointers=0, level_o=0, valid_o=0, data_out_o=0, accept_o=1, almost_full_o=0 (when AFULL_THRESH>0), overflow_o=0, drop_count_o=0.
- Write and read pointers are ADDR_W+1 bits; the MSB disambiguates full from empty, and both wrap modulo 2^(ADDR_W+1).
- accept_o = (level_o < DEPTH), taken from registered level only.
- A push at full is dropped even if a pop occurs in the same cycle.
- Accepted push (push_i & accept_o) writes RAM[wr_ptr] and increments wr_ptr and level.
- Dropped push (push_i & !accept_o) sets overflow_o and increments drop_count_o, saturating at all-ones. The RAM is unchanged.
- Pop (pop_i & valid_o) decrements level. Push and pop in the same cycle leave level unchanged.
- pop_i while valid_o=0 is ignored, with no side effects.
- Read side: the RAM read is registered, 1 cycle. A read is issued when the RAM is non-empty and the output stage is empty or being popped.
- Latency: a word pushed into an empty FIFO at edge N gives valid_o=1 after edge N+2.
- Skid buffer: while valid_o=1 and pop_i=0, data_out_o and valid_o hold stable, and no word is lost or duplicated.
- Order is strictly FIFO.
- Sustained push+pop throughput is one word per cycle once primed.
- flush_i=1 at an edge: pointers, level, output stage, overflow_o and drop_count_o all clear. valid_o=0 and accept_o=1 on the next cycle.
- flush_i overrides push_i and pop_i in the same cycle; the push is neither stored nor counted as dropped.
- RAM contents are not cleared by reset or flush; read-side logic must never expose stale data.
- Reset asserted mid-operation clears everything immediately. Outputs follow the reset values for as long as rst_ni=0.

Test Plan:
- Reset, then idle: valid_o=0, accept_o=1, level_o=0, drop_count_o=0; a pop_i pulse changes nothing.
- ADDR_W=4: push 0x100..0x10F back to back, no pop → level_o=16, accept_o=0, almost_full_o=1 (AFULL_THRESH=12). A 17th push → overflow_o=1, drop_count_o=1, level_o stays 16.
- Drain with pop_i=1 → data_out_o reads 0x100..0x10F in order, with valid_o low after the last word.
- Simultaneous push+pop at full → push dropped (drop_count_o increments), level_o goes 16→15.
- Backpressure: push 0xA, 0xB; hold pop_i=0 for 5 cycles → data_out_o=0xA stable with valid_o=1; then pop twice → 0xA then 0xB, no duplicates.
- Wrap: stream 40 words through ADDR_W=4 with random push/pop gaps → output sequence equals input, level_o never exceeds 16, and level_o always equals pushes minus pops.
- Flush mid-stream with 7 words held and overflow_o=1 → next cycle level_o=0, valid_o=0, overflow_o=0, drop_count_o=0. Then push 0x55 → 0x55 emerges 2 cycles later.
- Assert rst_ni=0 asynchronously between edges with 5 words held → outputs reach reset values immediately. After release, the FIFO behaves as empty.
